midi_voice_allocator: RTL and testbench

Upstream stage of the voice bank. Parses a raw MIDI byte stream (from the UART receiver) into Note On, Note Off and All-Notes-Off events and assigns notes to NUM_VOICES voice slots. Each slot's note, amplitude and enable outputs drive one voice instance's midi_data, amplitude and enable inputs. Accepts one byte per clock, has no backpressure, and keeps held per-voice registers.

---
 rtl/midi_voice_allocator.sv | 191 +++++++++++++++++++
 tb/tb_midi_voice_allocator.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/midi_voice_allocator.sv
// MIDI byte-stream parser and voice-slot allocator (note on/off, all-notes-off, round-robin steal).
// Latency: slot outputs and event_strobe update one clock after the edge that takes the completing byte.
// Backpressure: none; one byte per clock is accepted whenever midi_valid is high.
module midi_voice_allocator #(
    parameter int NUM_VOICES     = 4,
    parameter int AMPLITUDE_BITS = 8,
    parameter int MIDI_CHANNEL   = 0,
    parameter int OMNI           = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [7:0]                           midi_byte,
    input  logic                                 midi_valid,
    output logic [NUM_VOICES-1:0]                voice_enable,
    output logic [8*NUM_VOICES-1:0]              voice_note,
    output logic [AMPLITUDE_BITS*NUM_VOICES-1:0] voice_amplitude,
    output logic                                 event_strobe
);
    localparam int SPW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {IDLE, DATA1, DATA2} state_t;
    typedef enum logic [1:0] {EV_ON, EV_OFF, EV_ALL_OFF} ev_kind_t;

    state_t                    state, state_nxt;
    logic [7:0]                status, status_nxt;
    logic [6:0]                d1, d1_nxt;
    logic                      chan_ok;

    logic                      ev_vld, ev_vld_nxt;
    ev_kind_t                  ev_kind, ev_kind_nxt;
    logic [6:0]                ev_note, ev_note_nxt;
    logic [6:0]                ev_vel, ev_vel_nxt;

    logic [NUM_VOICES-1:0]     en_q, en_nxt;
    logic [6:0]                note_q   [NUM_VOICES];
    logic [6:0]                note_nxt [NUM_VOICES];
    logic [AMPLITUDE_BITS-1:0] amp_q    [NUM_VOICES];
    logic [AMPLITUDE_BITS-1:0] amp_nxt  [NUM_VOICES];
    logic [SPW-1:0]            steal_ptr, steal_ptr_nxt;
    logic                      strobe_nxt;

    logic                      hit, free;
    logic [SPW-1:0]            hit_idx, free_idx;
    logic [AMPLITUDE_BITS-1:0] ev_amp;

    assign chan_ok = (OMNI != 0) || (status[3:0] == 4'(MIDI_CHANNEL));

    // Parser: running status is valid exactly when state is not IDLE.
    always_comb begin
        state_nxt   = state;
        status_nxt  = status;
        d1_nxt      = d1;
        ev_vld_nxt  = 1'b0;
        ev_kind_nxt = EV_ON;
        ev_note_nxt = d1;
        ev_vel_nxt  = midi_byte[6:0];
        if (midi_valid) begin
            if (midi_byte >= 8'hF8) begin
                state_nxt = state;
            end else if (midi_byte >= 8'hF0) begin
                state_nxt  = IDLE;
                status_nxt = 8'h00;
            end else if (midi_byte[7]) begin
                state_nxt  = DATA1;
                status_nxt = midi_byte;
            end else begin
                case (state)
                    DATA1: begin
                        d1_nxt = midi_byte[6:0];
                        if (status[7:4] == 4'hC || status[7:4] == 4'hD)
                            state_nxt = DATA1;
                        else
                            state_nxt = DATA2;
                    end
                    DATA2: begin
                        state_nxt = DATA1;
                        if (chan_ok) begin
                            if (status[7:4] == 4'h9 && midi_byte[6:0] != 7'd0) begin
                                ev_vld_nxt  = 1'b1;
                                ev_kind_nxt = EV_ON;
                            end else if (status[7:4] == 4'h9 || status[7:4] == 4'h8) begin
                                ev_vld_nxt  = 1'b1;
                                ev_kind_nxt = EV_OFF;
                            end else if (status[7:4] == 4'hB && d1 == 7'd123) begin
                                ev_vld_nxt  = 1'b1;
                                ev_kind_nxt = EV_ALL_OFF;
                            end
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    assign ev_amp = AMPLITUDE_BITS'({ev_vel, ev_vel[6]});

    // Slot update: descending scans leave the lowest matching index.
    always_comb begin
        en_nxt        = en_q;
        note_nxt      = note_q;
        amp_nxt       = amp_q;
        steal_ptr_nxt = steal_ptr;
        strobe_nxt    = 1'b0;
        hit           = 1'b0;
        free          = 1'b0;
        hit_idx       = '0;
        free_idx      = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (en_q[i] && note_q[i] == ev_note) begin
                hit     = 1'b1;
                hit_idx = SPW'(i);
            end
            if (!en_q[i]) begin
                free     = 1'b1;
                free_idx = SPW'(i);
            end
        end
        if (ev_vld) begin
            case (ev_kind)
                EV_ON: begin
                    strobe_nxt = 1'b1;
                    if (hit) begin
                        amp_nxt[hit_idx] = ev_amp;
                    end else if (free) begin
                        note_nxt[free_idx] = ev_note;
                        amp_nxt[free_idx]  = ev_amp;
                        en_nxt[free_idx]   = 1'b1;
                    end else begin
                        note_nxt[steal_ptr] = ev_note;
                        amp_nxt[steal_ptr]  = ev_amp;
                        steal_ptr_nxt = (steal_ptr == SPW'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;
                    end
                end
                EV_OFF: begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (en_q[i] && note_q[i] == ev_note) begin
                            en_nxt[i]  = 1'b0;
                            strobe_nxt = 1'b1;
                        end
                    end
                end
                EV_ALL_OFF: begin
                    strobe_nxt = |en_q;
                    en_nxt     = '0;
                end
                default: strobe_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            status       <= 8'h00;
            d1           <= 7'd0;
            ev_vld       <= 1'b0;
            ev_kind      <= EV_ON;
            ev_note      <= 7'd0;
            ev_vel       <= 7'd0;
            en_q         <= '0;
            steal_ptr    <= '0;
            event_strobe <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                amp_q[i]  <= '0;
            end
        end else begin
            state        <= state_nxt;
            status       <= status_nxt;
            d1           <= d1_nxt;
            ev_vld       <= ev_vld_nxt;
            ev_kind      <= ev_kind_nxt;
            ev_note      <= ev_note_nxt;
            ev_vel       <= ev_vel_nxt;
            en_q         <= en_nxt;
            steal_ptr    <= steal_ptr_nxt;
            event_strobe <= strobe_nxt;
            note_q       <= note_nxt;
            amp_q        <= amp_nxt;
        end
    end

    always_comb begin
        voice_enable = en_q;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note[8*i +: 8]                           = {1'b0, note_q[i]};
            voice_amplitude[AMPLITUDE_BITS*i +: AMPLITUDE_BITS] = amp_q[i];
        end
    end
endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench for midi_voice_allocator with NUM_VOICES=4, channel 0, OMNI off.
module tb_midi_voice_allocator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  midi_byte = 8'h00;
    logic        midi_valid = 1'b0;
    logic [3:0]  voice_enable;
    logic [31:0] voice_note;
    logic [31:0] voice_amplitude;
    logic        event_strobe;

    int total = 0;
    int bad = 0;
    int strobe_cnt = 0;
    int s0;

    midi_voice_allocator #(.NUM_VOICES(4), .AMPLITUDE_BITS(8), .MIDI_CHANNEL(0), .OMNI(0)) dut (
        .clk(clk), .rst_n(rst_n), .midi_byte(midi_byte), .midi_valid(midi_valid),
        .voice_enable(voice_enable), .voice_note(voice_note),
        .voice_amplitude(voice_amplitude), .event_strobe(event_strobe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (event_strobe) strobe_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        midi_byte  = b;
        midi_valid = 1'b1;
        @(negedge clk);
        midi_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    function automatic logic [7:0] vnote(input int i);
        return voice_note[8*i +: 8];
    endfunction

    function automatic logic [7:0] vamp(input int i);
        return voice_amplitude[8*i +: 8];
    endfunction

    initial begin
        idle(2);
        chk("rst_en", 32'(voice_enable), 32'h0);
        chk("rst_note", voice_note, 32'h0);
        chk("rst_amp", voice_amplitude, 32'h0);
        chk("rst_strobe", 32'(event_strobe), 32'h0);
        rst_n = 1'b1;
        idle(1);

        // Basic note-on and one-cycle latency
        s0 = strobe_cnt;
        send(8'h90); send(8'h3C); send(8'h7F);
        chk("lat_en_early", 32'(voice_enable), 32'h0);
        idle(1);
        chk("on_strobe", 32'(event_strobe), 32'h1);
        chk("on_en", 32'(voice_enable), 32'h1);
        chk("on_note0", 32'(vnote(0)), 32'h3C);
        chk("on_amp0", 32'(vamp(0)), 32'hFF);
        chk("on_others", voice_note[31:8], 32'h0);
        idle(3);
        chk("on_pulses", 32'(strobe_cnt - s0), 32'h1);
        // Retrigger of held note: amplitude only
        send(8'h3C); send(8'h01); idle(2);
        chk("retrig_amp", 32'(vamp(0)), 32'h02);
        chk("retrig_en", 32'(voice_enable), 32'h1);
        chk("retrig_pulses", 32'(strobe_cnt - s0), 32'h2);

        // Running status and velocity-zero note-off
        do_reset();
        send(8'h90); send(8'h3C); send(8'h40); send(8'h40); send(8'h50); idle(2);
        chk("rs_note0", 32'(vnote(0)), 32'h3C);
        chk("rs_amp0", 32'(vamp(0)), 32'h81);
        chk("rs_note1", 32'(vnote(1)), 32'h40);
        chk("rs_amp1", 32'(vamp(1)), 32'hA1);
        send(8'h3C); send(8'h00); idle(2);
        chk("v0off_en", 32'(voice_enable), 32'h2);
        chk("v0off_note", 32'(vnote(0)), 32'h3C);

        // Voice stealing
        do_reset();
        send(8'h90);
        for (int n = 0; n < 5; n++) begin
            send(8'(8'h3C + n)); send(8'h7F);
        end
        idle(2);
        chk("steal_note0", 32'(vnote(0)), 32'h40);
        chk("steal_en", 32'(voice_enable), 32'hF);
        send(8'h41); send(8'h7F); idle(2);
        chk("steal_note1", 32'(vnote(1)), 32'h41);
        chk("steal_note2", 32'(vnote(2)), 32'h3E);

        // Real-time transparency and SysEx abort
        do_reset();
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h7F); idle(2);
        chk("rt_note0", 32'(vnote(0)), 32'h3C);
        chk("rt_en", 32'(voice_enable), 32'h1);
        s0 = strobe_cnt;
        send(8'h90); send(8'h3D); send(8'hF0); send(8'h3D); send(8'h7F); idle(3);
        chk("sysex_en", 32'(voice_enable), 32'h1);
        chk("sysex_pulses", 32'(strobe_cnt - s0), 32'h0);

        // Channel filter, note-off, all-notes-off
        do_reset();
        s0 = strobe_cnt;
        send(8'h91); send(8'h3C); send(8'h7F); idle(3);
        chk("chan_en", 32'(voice_enable), 32'h0);
        chk("chan_pulses", 32'(strobe_cnt - s0), 32'h0);
        send(8'h90); send(8'h3C); send(8'h7F); send(8'h3D); send(8'h7F);
        send(8'h3E); send(8'h7F); idle(2);
        chk("three_en", 32'(voice_enable), 32'h7);
        send(8'h80); send(8'h3D); send(8'h40); idle(2);
        chk("noteoff_en", 32'(voice_enable), 32'h5);
        s0 = strobe_cnt;
        send(8'h80); send(8'h50); send(8'h40); idle(2);
        chk("noteoff_miss", 32'(strobe_cnt - s0), 32'h0);
        send(8'hB0); send(8'h7B); send(8'h00); idle(2);
        chk("alloff_en", 32'(voice_enable), 32'h0);
        chk("alloff_note2", 32'(vnote(2)), 32'h3E);
        chk("alloff_pulses", 32'(strobe_cnt - s0), 32'h1);

        // Reset in the middle of a message
        send(8'h90); send(8'h3C); send(8'h7F); idle(1);
        send(8'h90); send(8'h3D);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_en", 32'(voice_enable), 32'h0);
        chk("midrst_note", voice_note, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        s0 = strobe_cnt;
        send(8'h3C); send(8'h7F); idle(3);
        chk("norun_en", 32'(voice_enable), 32'h0);
        chk("norun_pulses", 32'(strobe_cnt - s0), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
